// File: rtl/btn_pkg.sv
// btn_pkg: shared constants for the push-button conditioning front end.
// Button indices, the per-button FSM encoding, default timing values and
// the fixed-priority grant helper used by the arbiter.
package btn_pkg;

   localparam int NUM_BTN = 5;

   // Bit positions inside btn_raw / btn_level, bit order {L,R,D,U,C}
   localparam int BTN_C = 0;
   localparam int BTN_U = 1;
   localparam int BTN_D = 2;
   localparam int BTN_R = 3;
   localparam int BTN_L = 4;

   // Defaults sized for a 48.8 kHz clock: ~20 ms, ~400 ms, ~150 ms
   localparam int DEF_DEBOUNCE_CYCLES = 976;
   localparam int DEF_REPEAT_DELAY    = 19520;
   localparam int DEF_REPEAT_PERIOD   = 7320;

   // Bit 1 of the encoding is the accepted (debounced) level
   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_PRESSING  = 2'b01,
      ST_HELD      = 2'b10,
      ST_RELEASING = 2'b11
   } btn_state_e;

   function automatic logic state_level(input btn_state_e st);
      return st[1];
   endfunction

   // One-hot grant of the lowest set index; index 0 (C) has top priority
   function automatic logic [NUM_BTN-1:0] prio_grant(input logic [NUM_BTN-1:0] req);
      logic [NUM_BTN-1:0] g;
      g = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (req[i] && (g == '0)) g[i] = 1'b1;
      end
      return g;
   endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: pad-side inputs and game-board-side outputs of the
// button conditioner. The master drives the raw pads, the slave is the
// conditioner itself.
interface button_conditioner_if;
   import btn_pkg::*;

   logic [NUM_BTN-1:0] btn_raw;
   logic               BTNC;
   logic               BTNU;
   logic               BTND;
   logic               BTNR;
   logic               BTNL;
   logic [NUM_BTN-1:0] btn_level;

   modport master (
      output btn_raw,
      input  BTNC, BTNU, BTND, BTNR, BTNL, btn_level
   );

   modport slave (
      input  btn_raw,
      output BTNC, BTNU, BTND, BTNR, BTNL, btn_level
   );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: one button's synchroniser, stability counter, press FSM and
// (when BTN_REPEAT_EN is defined) auto-repeat counter. event_o is high for
// the one cycle before the edge at which a press is accepted, and for each
// auto-repeat tick; the top registers it into its pending flag.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int BTN_IDX         = BTN_C
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic level_o,
   output logic event_o
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Repeat reload assumes REPEAT_DELAY >= REPEAT_PERIOD
   if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD ||
       BTN_IDX < 0 || BTN_IDX >= NUM_BTN) begin : g_bad_cfg
      $error("btn_debounce: invalid timing or index configuration");
   end

   logic             meta_q, sync_q;
   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             differs, terminal, press_evt, repeat_evt;

   // Two-flop synchroniser for the asynchronous pad level
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking so every flop samples pre-edge values and the chain really is two stages.
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= raw_i;
         sync_q <= meta_q;
      end
   end

   assign level_o  = state_level(state_q);
   assign differs  = (sync_q != level_o);
   assign terminal = differs && (cnt_q == CNT_TERM);

   // Stability counter: run length of cycles disagreeing with the accepted level
   always_comb begin
      // NOTE: default first so every path assigns cnt_d and no latch is inferred.
      cnt_d = '0;
      if (differs && !terminal) cnt_d = cnt_q + 1'b1;
   end

   // Next state: a completed run commits the new level, any bounce aborts it
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (sync_q) state_d = ST_PRESSING;
         ST_PRESSING:  if (!sync_q) state_d = ST_IDLE;
                       else if (terminal) state_d = ST_HELD;
         ST_HELD:      if (!sync_q) state_d = ST_RELEASING;
         ST_RELEASING: if (sync_q) state_d = ST_HELD;
                       else if (terminal) state_d = ST_IDLE;
      endcase
   end

   // FSM state and stability counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Only an accepted press raises an event; a release-bounce back to HELD does not
   assign press_evt = (state_q == ST_PRESSING) && (state_d == ST_HELD);

`ifdef BTN_REPEAT_EN
   if (BTN_IDX != BTN_C) begin : g_repeat
      localparam int               RPT_W      = $clog2(REPEAT_DELAY);
      localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
      localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

      logic [RPT_W-1:0] rpt_q, rpt_d;

      // Hold timer: counts continuous HELD cycles, reloads so later ticks are REPEAT_PERIOD apart
      always_comb begin
         rpt_d = '0;
         if (state_q == ST_HELD && state_d == ST_HELD)
            rpt_d = (rpt_q == RPT_LAST) ? RPT_RELOAD : rpt_q + 1'b1;
      end

      // Hold timer register
      always_ff @(posedge clk or posedge reset) begin
         if (reset) rpt_q <= '0;
         else       rpt_q <= rpt_d;
      end

      assign repeat_evt = (state_q == ST_HELD) && (rpt_q == RPT_LAST);
   end else begin : g_no_repeat
      assign repeat_evt = 1'b0;
   end
`else
   assign repeat_evt = 1'b0;
`endif

   assign event_o = press_evt | repeat_evt;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: five debounced buttons feeding a pending-flag register
// and a fixed-priority (C > U > D > R > L) single-pulse arbiter. All outputs
// are registered. Optional feature: define BTN_REPEAT_EN for auto-repeat on
// U/D/R/L while held.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input logic                 clk,
   input logic                 reset,
   button_conditioner_if.slave bus
);

   logic [NUM_BTN-1:0] evt, level, grant;
   logic [NUM_BTN-1:0] pend_q, pend_d;
   logic [NUM_BTN-1:0] pulse_q;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
         .BTN_IDX         (i)
      ) u_debounce (
         .clk     (clk),
         .reset   (reset),
         .raw_i   (bus.btn_raw[i]),
         .level_o (level[i]),
         .event_o (evt[i])
      );
   end

   // Grant the top pending request; a fresh event on the granted bit keeps it pending
   always_comb begin
      grant  = prio_grant(pend_q);
      pend_d = (pend_q & ~grant) | evt;
   end

   // Pending flags and registered one-cycle pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q  <= '0;
         pulse_q <= '0;
      end else begin
         pend_q  <= pend_d;
         pulse_q <= grant;
      end
   end

   assign bus.btn_level = level;
   assign bus.BTNC      = pulse_q[BTN_C];
   assign bus.BTNU      = pulse_q[BTN_U];
   assign bus.BTND      = pulse_q[BTN_D];
   assign bus.BTNR      = pulse_q[BTN_R];
   assign bus.BTNL      = pulse_q[BTN_L];

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench. A reference model, written as
// "accept a level once the last DEBOUNCE_CYCLES synchronised samples all
// disagree with it", pushes the expected levels/pulses each clock; a monitor
// pops and compares on the falling edge. Directed scenarios add absolute
// latency checks. Define BTN_REPEAT_EN to build the auto-repeat variant.
module tb_button_conditioner;
   import btn_pkg::*;

   localparam int DC = 4;
   localparam int RD = 20;
   localparam int RP = 8;
`ifdef BTN_REPEAT_EN
   localparam bit RPT = 1'b1;
`else
   localparam bit RPT = 1'b0;
`endif

   typedef struct packed {
      logic [NUM_BTN-1:0] level;
      logic [NUM_BTN-1:0] pulse;
   } exp_t;

   logic clk;
   logic reset;
   button_conditioner_if bif ();

   button_conditioner #(
      .DEBOUNCE_CYCLES (DC),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   pulse_cnt[NUM_BTN];
   int   last_pulse[NUM_BTN];
   int   lvl_rise[NUM_BTN];
   int   lvl_fall[NUM_BTN];
   int   l_times[$];

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic logic [NUM_BTN-1:0] pulses();
      return {bif.BTNL, bif.BTNR, bif.BTND, bif.BTNU, bif.BTNC};
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge index: after posedge n, cyc == n
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model
   initial begin : model
      logic [NUM_BTN-1:0] m_s1, m_s, m_lvl, m_held, m_pend, m_pulse, s_cur, held_cur, evt;
      int hist[NUM_BTN];
      int age[NUM_BTN];
      int mask;
      mask = (1 << DC) - 1;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_s1 = '0; m_s = '0; m_lvl = '0; m_held = '0; m_pend = '0; m_pulse = '0;
            for (int i = 0; i < NUM_BTN; i++) begin
               hist[i] = 0;
               age[i]  = 0;
            end
            exp_q.delete();
         end else begin
            s_cur    = m_s;
            held_cur = m_held;
            evt      = '0;
            m_s      = m_s1;
            m_s1     = bif.btn_raw;
            for (int i = 0; i < NUM_BTN; i++) begin
               hist[i] = ((hist[i] << 1) | int'(s_cur[i])) & mask;
               // Flip once the whole window disagrees with the accepted level
               if (hist[i] == (m_lvl[i] ? 0 : mask)) begin
                  if (!m_lvl[i]) evt[i] = 1'b1;
                  m_lvl[i] = ~m_lvl[i];
               end
               if (RPT && i != BTN_C && held_cur[i] && age[i] >= RD - 1 &&
                   ((age[i] - (RD - 1)) % RP) == 0)
                  evt[i] = 1'b1;
               m_held[i] = m_lvl[i] && s_cur[i];
               age[i]    = (held_cur[i] && m_held[i]) ? age[i] + 1 : 0;
            end
            m_pulse = '0;
            for (int i = 0; i < NUM_BTN; i++) begin
               if (m_pend[i] && m_pulse == '0) m_pulse[i] = 1'b1;
            end
            m_pend = (m_pend & ~m_pulse) | evt;
            exp_q.push_back('{level: m_lvl, pulse: m_pulse});
         end
      end
   end

   // Monitor: compares every cycle and records pulse/level timestamps
   initial begin : monitor
      exp_t               e;
      logic [NUM_BTN-1:0] pul, lvl, prev_lvl;
      prev_lvl = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         pulse_cnt[i] = 0; last_pulse[i] = -1; lvl_rise[i] = -1; lvl_fall[i] = -1;
      end
      forever begin
         @(negedge clk);
         pul = pulses();
         lvl = bif.btn_level;
         if (reset) begin
            check("outputs_in_reset", int'({pul, lvl}), 0);
         end else if (exp_q.size() == 0) begin
            check("scoreboard_has_entry", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            check("btn_level", int'(lvl), int'(e.level));
            check("pulses", int'(pul), int'(e.pulse));
         end
         for (int i = 0; i < NUM_BTN; i++) begin
            if (pul[i]) begin
               pulse_cnt[i]++;
               last_pulse[i] = cyc;
               if (i == BTN_L) l_times.push_back(cyc);
            end
            if (lvl[i] && !prev_lvl[i]) lvl_rise[i] = cyc;
            if (!lvl[i] && prev_lvl[i]) lvl_fall[i] = cyc;
         end
         prev_lvl = lvl;
      end
   end

   // Wait n rising edges, then step 2 time units clear of the edge
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin : stimulus
      int e0;
      int base, base_r;
      int offs[$];
      reset       = 1'b1;
      bif.btn_raw = '0;
      tick(3);
      @(negedge clk); #2;
      reset = 1'b0;
      tick(3);
      check("idle_level", int'(bif.btn_level), 0);
      check("idle_pulses", int'(pulses()), 0);

      // Clean press and release of U
      e0 = cyc + 1; base = pulse_cnt[BTN_U];
      bif.btn_raw[BTN_U] = 1'b1;
      tick(12);
      check("u_level_rise_edge", lvl_rise[BTN_U], e0 + DC + 1);
      check("u_pulse_edge", last_pulse[BTN_U], e0 + DC + 2);
      check("u_pulse_cycles", pulse_cnt[BTN_U] - base, 1);
      e0 = cyc + 1; base = pulse_cnt[BTN_U];
      bif.btn_raw[BTN_U] = 1'b0;
      tick(12);
      check("u_level_fall_edge", lvl_fall[BTN_U], e0 + DC + 1);
      check("u_release_pulses", pulse_cnt[BTN_U] - base, 0);

      // Bouncing C: 1,0,1 at 2-cycle spacing, then held
      base = pulse_cnt[BTN_C];
      bif.btn_raw[BTN_C] = 1'b1; tick(2);
      bif.btn_raw[BTN_C] = 1'b0; tick(2);
      e0 = cyc + 1;
      bif.btn_raw[BTN_C] = 1'b1;
      tick(14);
      check("c_bounce_pulse_edge", last_pulse[BTN_C], e0 + DC + 2);
      check("c_bounce_pulse_cycles", pulse_cnt[BTN_C] - base, 1);
      bif.btn_raw[BTN_C] = 1'b0;
      tick(12);

      // Simultaneous R and C
      e0 = cyc + 1; base = pulse_cnt[BTN_C]; base_r = pulse_cnt[BTN_R];
      bif.btn_raw[BTN_C] = 1'b1; bif.btn_raw[BTN_R] = 1'b1;
      tick(14);
      check("rc_c_pulse_edge", last_pulse[BTN_C], e0 + DC + 2);
      check("rc_r_pulse_edge", last_pulse[BTN_R], e0 + DC + 3);
      check("rc_c_pulse_cycles", pulse_cnt[BTN_C] - base, 1);
      check("rc_r_pulse_cycles", pulse_cnt[BTN_R] - base_r, 1);
      bif.btn_raw = '0;
      tick(12);

      // Reset while D is pressing, with U held at level 1
      bif.btn_raw[BTN_U] = 1'b1;
      tick(10);
      bif.btn_raw[BTN_D] = 1'b1;
      tick(4);
      check("pre_reset_u_level", int'(bif.btn_level[BTN_U]), 1);
      base = pulse_cnt[BTN_D];
      reset = 1'b1;
      #1;
      check("reset_async_level", int'(bif.btn_level), 0);
      check("reset_async_pulses", int'(pulses()), 0);
      bif.btn_raw[BTN_U] = 1'b0;
      tick(3);
      @(negedge clk); #2;
      e0 = cyc + 1;
      reset = 1'b0;
      tick(14);
      check("d_after_reset_pulse_edge", last_pulse[BTN_D], e0 + DC + 2);
      check("d_after_reset_pulse_cycles", pulse_cnt[BTN_D] - base, 1);
      bif.btn_raw = '0;
      tick(12);

      // L held for 50 cycles
`ifdef BTN_REPEAT_EN
      offs = '{0, RD, RD + RP, RD + 2 * RP, RD + 3 * RP};
`else
      offs = '{0};
`endif
      e0 = cyc + 1; base = pulse_cnt[BTN_L];
      l_times.delete();
      bif.btn_raw[BTN_L] = 1'b1;
      tick(50);
      bif.btn_raw[BTN_L] = 1'b0;
      tick(14);
      check("l_hold_pulse_count", pulse_cnt[BTN_L] - base, offs.size());
      for (int i = 0; i < offs.size(); i++) begin
         check($sformatf("l_hold_pulse%0d_edge", i),
               (i < l_times.size()) ? l_times[i] : -1, e0 + DC + 2 + offs[i]);
      end

      // C held for 50 cycles never repeats
      base = pulse_cnt[BTN_C];
      bif.btn_raw[BTN_C] = 1'b1;
      tick(50);
      bif.btn_raw[BTN_C] = 1'b0;
      tick(14);
      check("c_hold_pulse_count", pulse_cnt[BTN_C] - base, 1);

      // Randomised pad activity, checked cycle by cycle by the scoreboard
      repeat (80) begin
         bif.btn_raw = NUM_BTN'($urandom);
         tick($urandom_range(1, 30));
      end
      bif.btn_raw = '0;
      tick(40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
